// File: rtl/reg_dump_pkg.sv
// Shared types and sizes for the register-file dump engine.
// The CSUM state exists only when REG_DUMP_CHECKSUM_EN is defined.
package reg_dump_pkg;

    localparam int REG_COUNT = 32;
    localparam int IDX_W     = 5;
    localparam int REG_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_HOLD = 3'd2,
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4
    } reg_dump_state_t;

endpackage

// File: rtl/reg_dump_csum.sv
// Wrapping sum of every register value captured during one dump.
// Instantiated only when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_csum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         add,
    input  logic [W-1:0] value,
    output logic [W-1:0] sum
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + value;
        end
    end

endmodule

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a register index range via read port A1 and streams the values.
// Define REG_DUMP_CHECKSUM_EN to append a checksum beat after the last register.
module reg_dump_reader #(
    parameter int REG_W = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             abort,
    output logic [IDX_W-1:0] rf_addr,
    input  logic [REG_W-1:0] rf_data,
    output logic             dump_busy,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [REG_W-1:0] dout_data,
    output logic [IDX_W-1:0] dout_idx,
    output logic             dout_last,
    output logic             done
);
    import reg_dump_pkg::*;

    reg_dump_state_t  state;
    reg_dump_state_t  state_next;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] end_idx;
    logic             hs;
    logic             at_end;

    assign hs      = dout_valid && dout_ready;
    assign at_end  = (cur_idx == end_idx);
    assign rf_addr = cur_idx;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [REG_W-1:0] csum_value;

    reg_dump_csum #(.W(REG_W)) u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE && start),
        .add   (state == ST_READ),
        .value (rf_data),
        .sum   (csum_value)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // dump_busy drops in DONE so it falls in the same cycle done rises
    always_comb begin
        state_next = state;
        dump_busy  = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_READ;
            end
            ST_READ: begin
                dump_busy  = 1'b1;
                state_next = abort ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                dump_busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (hs) begin
                    if (!at_end) begin
                        state_next = ST_READ;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_DONE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                dump_busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (hs) begin
                    state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Beat registers snapshot rf_data at the READ edge and hold it through HOLD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_idx    <= '0;
            end_idx    <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_idx   <= '0;
            dout_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_idx <= first_idx;
                        end_idx <= last_idx;
                    end
                end
                ST_READ: begin
                    if (!abort) begin
                        dout_data  <= rf_data;
                        dout_idx   <= cur_idx;
                        dout_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        dout_last  <= 1'b0;
`else
                        dout_last  <= at_end;
`endif
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                    end else if (hs) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        if (!at_end) begin
                            cur_idx <= cur_idx + 1'b1;
                        end
`ifdef REG_DUMP_CHECKSUM_EN
                        else begin
                            dout_data  <= csum_value;
                            dout_idx   <= '0;
                            dout_last  <= 1'b1;
                            dout_valid <= 1'b1;
                        end
`endif
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (abort || hs) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader; expected checksum beats follow REG_DUMP_CHECKSUM_EN.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dout_ready = 1'b0;
    logic [4:0]  first_idx = '0;
    logic [4:0]  last_idx = '0;
    logic [4:0]  rf_addr;
    logic [4:0]  dout_idx;
    logic [31:0] rf_data;
    logic [31:0] dout_data;
    logic        dump_busy;
    logic        dout_valid;
    logic        dout_last;
    logic        done;
    logic [31:0] rf [32];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rf_data = rf[rf_addr];

    reg_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .abort      (abort),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .dump_busy  (dump_busy),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last),
        .done       (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // One full dump; optionally writes a register or pulses start while a beat is held
    task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l, input int stall,
                                 input int writeIdx, input logic [31:0] writeVal, input int startIdx);
        int          n;
        int          total;
        int          waitCnt;
        bit          isCsum;
        logic [4:0]  idx;
        logic [31:0] expData;
        logic [31:0] expIdx;
        logic [31:0] sum;
        n = ((int'(l) - int'(f)) & 31) + 1;
`ifdef REG_DUMP_CHECKSUM_EN
        total = n + 1;
`else
        total = n;
`endif
        @(negedge clk);
        first_idx  = f;
        last_idx   = l;
        start      = 1'b1;
        dout_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_rise", dump_busy, 1);
        checkOutput("valid_early", dout_valid, 0);
        checkOutput("rf_addr_first", rf_addr, f);
        idx = f;
        sum = '0;
        for (int b = 0; b < total; b++) begin
            isCsum  = (b == n);
            waitCnt = 0;
            while (!dout_valid && waitCnt < 4) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!dout_valid) begin
                checkOutput("valid_timeout", 0, 1);
                return;
            end
            checkOutput("beat_latency", waitCnt, isCsum ? 0 : 1);
            expData = isCsum ? sum : rf[idx];
            expIdx  = isCsum ? 0 : 32'(idx);
            checkOutput("beat_idx", dout_idx, expIdx);
            checkOutput("beat_data", dout_data, expData);
            checkOutput("beat_last", dout_last, (b == total - 1) ? 1 : 0);
            for (int s = 0; s < stall; s++) begin
                if (!isCsum && int'(idx) == writeIdx && s == 0) rf[idx] = writeVal;
                @(negedge clk);
                checkOutput("stall_valid", dout_valid, 1);
                checkOutput("stall_data", dout_data, expData);
                checkOutput("stall_idx", dout_idx, expIdx);
            end
            if (!isCsum) sum = sum + expData;
            dout_ready = 1'b1;
            if (!isCsum && int'(idx) == startIdx) begin
                start     = 1'b1;
                first_idx = 5'd0;
                last_idx  = 5'd0;
            end
            @(negedge clk);
            dout_ready = 1'b0;
            start      = 1'b0;
            idx        = idx + 5'd1;
        end
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_fall", dump_busy, 0);
        checkOutput("valid_after_last", dout_valid, 0);
        @(negedge clk);
        checkOutput("done_single", done, 0);
        checkOutput("idle_busy", dump_busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneSeen;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);

        #2;
        checkOutput("rst_valid", dout_valid, 0);
        checkOutput("rst_data", dout_data, 0);
        checkOutput("rst_idx", dout_idx, 0);
        checkOutput("rst_last", dout_last, 0);
        checkOutput("rst_busy", dump_busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_addr", rf_addr, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] full dump 0..31");
        applyStimulus(5'd0, 5'd31, 0, -1, 32'h0, -1);

        $display("[TB] stalled dump 5..7");
        applyStimulus(5'd5, 5'd7, 4, -1, 32'h0, -1);

        $display("[TB] wrapping dump 30..1");
        applyStimulus(5'd30, 5'd1, 0, -1, 32'h0, -1);

        $display("[TB] snapshot: write reg 3 during its hold");
        applyStimulus(5'd2, 5'd4, 2, 3, 32'hDEADBEEF, -1);
        applyStimulus(5'd3, 5'd3, 0, -1, 32'h0, -1);
        checkOutput("snapshot_rf3", rf[3], 32'hDEADBEEF);

        $display("[TB] abort in hold of second beat");
        @(negedge clk);
        first_idx = 5'd10;
        last_idx  = 5'd15;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort_beat0_idx", dout_idx, 10);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        @(negedge clk);
        checkOutput("abort_beat1_valid", dout_valid, 1);
        checkOutput("abort_beat1_idx", dout_idx, 11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_valid", dout_valid, 0);
        checkOutput("abort_busy", dump_busy, 0);
        doneSeen = int'(done);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            doneSeen += int'(done);
        end
        checkOutput("abort_no_done", doneSeen, 0);
        applyStimulus(5'd10, 5'd11, 1, -1, 32'h0, -1);

        $display("[TB] reset mid-dump");
        @(negedge clk);
        first_idx = 5'd0;
        last_idx  = 5'd31;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        @(negedge clk);
        checkOutput("mid_valid", dout_valid, 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", dout_valid, 0);
        checkOutput("mid_rst_data", dout_data, 0);
        checkOutput("mid_rst_idx", dout_idx, 0);
        checkOutput("mid_rst_last", dout_last, 0);
        checkOutput("mid_rst_busy", dump_busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_addr", rf_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_busy", dump_busy, 0);
        checkOutput("post_rst_done", done, 0);

        $display("[TB] start while busy is ignored");
        applyStimulus(5'd20, 5'd22, 1, -1, 32'h0, 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the MIPS register file. On a start request it takes over one register-file read port and walks an index range upward, modulo 32. Each register value is presented on a valid/ready output stream tagged with its index. Its `dump_busy` output is the select for the core's A1 mux and its stall request; the core must not depend on RD1 while `dump_busy` is high.

## Interface
- `REG_W`, 32, register data width
- `IDX_W`, 5, register index width (32 registers)
- `clk` input 1: clock, rising edge
- `rst` input 1: asynchronous, active-low reset
- `start` input 1: one-cycle request; sampled only in IDLE
- `first_idx` input IDX_W: first register to dump, latched on accepted `start`
- `last_idx` input IDX_W: last register to dump, inclusive, latched on accepted `start`
- `abort` input 1: synchronous cancel of a dump in progress
- `rf_addr` output IDX_W: read address, muxed onto register-file A1 while `dump_busy` is high
- `rf_data` input REG_W: combinational read data (RD1) for `rf_addr`
- `dump_busy` output 1: high from the cycle after `start` acceptance until return to IDLE
- `dout_valid` output 1: output beat valid
- `dout_ready` input 1: sink accepts the beat
- `dout_data` output REG_W: register value, or checksum on the checksum beat
- `dout_idx` output IDX_W: register index of the beat; 0 on the checksum beat
- `dout_last` output 1: final beat of the dump
- `done` output 1: one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, READ, HOLD, CSUM (present only with the macro), DONE.
- **IDLE:** `start`=1 latches `cur_idx`=`first_idx` and `end_idx`=`last_idx`, clears the checksum, and moves to READ.
- **READ:** `rf_addr`=`cur_idx`. At the clock edge:
  - `dout_data` captures `rf_data`;
  - `dout_idx` captures `cur_idx`;
  - `dout_valid` rises;
  - the FSM moves to HOLD.
- **HOLD:** the beat is held stable until `dout_valid`&&`dout_ready`. On that handshake:
  - if `cur_idx`==`end_idx`, go to CSUM when enabled, otherwise DONE;
  - else `cur_idx`=`cur_idx`+1 mod 32 and go to READ.
- **CSUM:** present `dout_data`=checksum, `dout_idx`=0, `dout_last`=1, held until the handshake, then go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- `dout_last` is 1 on the final beat only: the last register beat without the macro, the checksum beat with it.
- Range and wrap:
  - beat count = ((`last_idx`−`first_idx`) mod 32)+1;
  - `first_idx`==`last_idx` gives exactly 1 register beat;
  - `first_idx`>`last_idx` wraps, e.g. 30 to 1 gives 30, 31, 0, 1.
- Snapshot rule: a beat carries the register value at its READ edge. Later writes to that register while in HOLD do not change `dout_data`.
- `abort`:
  - in READ, HOLD or CSUM: next cycle `dout_valid`=0 and the FSM is in IDLE; no `done` pulse;
  - in IDLE or DONE: ignored.
- `start` asserted outside IDLE is ignored.

## Timing
- Reset (`rst` low, asynchronous) forces:
  - state IDLE;
  - `rf_addr`=0, `dout_valid`=0, `dout_data`=0, `dout_idx`=0, `dout_last`=0;
  - `done`=0, `dump_busy`=0, checksum=0.
- `rst` low mid-dump forces these values immediately, with no `done` pulse.
- Latency:
  - `start` at cycle 0 gives `dump_busy` and READ at cycle 1;
  - the first `dout_valid` is at cycle 2;
  - with `dout_ready` held at 1, beats arrive every 2 cycles.
- `done` is asserted in the cycle after the final handshake; `dump_busy` falls together with it.
- `dout_ready` may toggle freely. `dout_valid` never drops without a handshake, `abort`, or reset.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined:
  - a 32-bit wrapping sum of all dumped register values is accumulated at each READ capture;
  - the sum is emitted as one extra CSUM beat carrying `dout_last`.
- `REG_DUMP_CHECKSUM_EN` undefined: no accumulator and no CSUM state; the last register beat carries `dout_last`.

## Structure
- Package `reg_dump_pkg`: state enum `reg_dump_state_t`, `REG_COUNT`=32, `IDX_W`=5, `REG_W`=32.
- Sub-module `reg_dump_csum` (accumulator: clear, add, value) is instantiated only under `REG_DUMP_CHECKSUM_EN`.
- The register-file A1 mux stays in the core, selected by `dump_busy`.

## Test plan
- After reset, dump 0 to 31 with `dout_ready`=1 → 32 beats with `dout_data`=`dout_idx`=i; with the macro, a checksum beat of 0x1F0 follows; `done` pulses once.
- Dump 5 to 7 with `dout_ready` low for 4 cycles per beat → beats 5, 6, 7 held stable during each stall; with the macro, checksum 0x12.
- Dump 30 to 1 → indices 30, 31, 0, 1 in order, and `dout_last` on the correct beat.
- Write reg 3=0xDEADBEEF during the HOLD of beat 3 → `dout_data` stays 3; a re-dump of 3 to 3 gives 0xDEADBEEF as a single beat.
- Assert `abort` in the HOLD of the second beat → `dout_valid` is 0 next cycle, no `done`; a new `start` then works normally.
- Assert `rst` low mid-dump, and separately assert `start` while `dump_busy` is high → all outputs return to reset values immediately; the `start` while busy is ignored.
